// File: rtl/ttrng_collector.sv
// TTRNG raw-bit collector: von Neumann debiasing, MSB-first byte packing, valid/ack output register.
// Optional repetition-count health test is built when TTRNG_HEALTH_EN is defined.
module ttrng_collector #(
    parameter int unsigned REP_LIMIT = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       raw_bit,
    input  logic       raw_valid,
    input  logic       ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       overrun,
    output logic       health_fail
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} pair_state_t;

    if (REP_LIMIT < 2 || REP_LIMIT > 255) begin : g_bad_rep_limit
        $error("ttrng_collector: REP_LIMIT out of range 2..255");
    end

    pair_state_t state_r;
    pair_state_t state_nxt_s;
    logic        first_r;
    logic        accept_s;
    logic        emit_s;
    logic [2:0]  cnt_r;
    logic [2:0]  cnt_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic [7:0]  byte_s;
    logic        byte_done_s;
    logic        block_s;
    logic        load_s;
    logic        drop_s;
    logic [7:0]  data_out_r;
    logic        data_valid_r;
    logic        data_valid_nxt_s;
    logic        overrun_r;

    assign accept_s = ena & raw_valid;

    // Pair FSM state register; first bit of a pair captured on entry to HELD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= EMPTY;
            first_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s && state_r == EMPTY) begin
                first_r <= raw_bit;
            end else begin
                first_r <= first_r;
            end
        end
    end

    // Pair FSM next state; a low enable abandons any half-collected pair.
    always_comb begin
        state_nxt_s = state_r;
        if (!ena) begin
            state_nxt_s = EMPTY;
        end else if (raw_valid) begin
            case (state_r)
                EMPTY:   state_nxt_s = HELD;
                HELD:    state_nxt_s = EMPTY;
                default: state_nxt_s = EMPTY;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Pair FSM output: unequal pair emits its first bit.
    always_comb begin
        emit_s = 1'b0;
        if (accept_s && state_r == HELD && first_r != raw_bit) begin
            emit_s = 1'b1;
        end else begin
            emit_s = 1'b0;
        end
    end

`ifdef TTRNG_HEALTH_EN
    localparam logic [7:0] REP_LIMIT_W = 8'(REP_LIMIT);

    logic [7:0] rep_cnt_r;
    logic [7:0] rep_nxt_s;
    logic       last_bit_r;
    logic       health_fail_r;

    // Saturating run length of identical accepted raw bits.
    always_comb begin
        rep_nxt_s = rep_cnt_r;
        if (!accept_s) begin
            rep_nxt_s = rep_cnt_r;
        end else if (rep_cnt_r == 8'd0 || raw_bit != last_bit_r) begin
            rep_nxt_s = 8'd1;
        end else if (rep_cnt_r != 8'hFF) begin
            rep_nxt_s = rep_cnt_r + 8'd1;
        end else begin
            rep_nxt_s = rep_cnt_r;
        end
    end

    // Health test registers; the failure flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rep_cnt_r     <= 8'd0;
            last_bit_r    <= 1'b0;
            health_fail_r <= 1'b0;
        end else begin
            rep_cnt_r <= rep_nxt_s;
            if (accept_s) begin
                last_bit_r <= raw_bit;
            end else begin
                last_bit_r <= last_bit_r;
            end
            if (accept_s && rep_nxt_s == REP_LIMIT_W) begin
                health_fail_r <= 1'b1;
            end else begin
                health_fail_r <= health_fail_r;
            end
        end
    end

    assign block_s     = health_fail_r;
    assign health_fail = health_fail_r;
`else
    assign block_s     = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign byte_s      = {shift_r[6:0], first_r};
    assign byte_done_s = emit_s && (cnt_r == 3'd7);

    // Packing and hand-off decisions: a byte loads if the register is free this edge.
    always_comb begin
        cnt_nxt_s        = cnt_r;
        shift_nxt_s      = shift_r;
        load_s           = 1'b0;
        drop_s           = 1'b0;
        data_valid_nxt_s = data_valid_r;
        if (emit_s) begin
            shift_nxt_s = byte_s;
            cnt_nxt_s   = byte_done_s ? 3'd0 : cnt_r + 3'd1;
        end else begin
            shift_nxt_s = shift_r;
            cnt_nxt_s   = cnt_r;
        end
        if (byte_done_s && !block_s) begin
            load_s = !data_valid_r || ack;
            drop_s = data_valid_r && !ack;
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
        if (load_s) begin
            data_valid_nxt_s = 1'b1;
        end else if (data_valid_r && ack) begin
            data_valid_nxt_s = 1'b0;
        end else begin
            data_valid_nxt_s = data_valid_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r        <= 3'd0;
            shift_r      <= 8'd0;
            data_out_r   <= 8'd0;
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            cnt_r        <= cnt_nxt_s;
            shift_r      <= shift_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            overrun_r    <= overrun_r | drop_s;
            if (load_s) begin
                data_out_r <= byte_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_ttrng_collector.sv
// Directed bench for ttrng_collector: table of debiased byte streams plus hand-written corner sequences.
module tb_ttrng_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       raw_bit = 1'b0;
    logic       raw_valid = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       overrun;
    logic       health_fail;

    int checks = 0;
    int errors = 0;

    ttrng_collector #(.REP_LIMIT(31)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .ack(ack), .data_out(data_out), .data_valid(data_valid), .overrun(overrun),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] raw;
        logic        ins_eq;
        logic        ena_gap;
        logic [7:0]  exp;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ena = 1'b1;
        raw_valid = 1'b1;
        raw_bit = b;
        @(posedge clk);
        #1;
        raw_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] r, input int n);
        for (int i = 15; i > 15 - n; i--) send_bit(r[i]);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        // Raw encodings: each debiased 1 is pair 10, each 0 is pair 01.
        vecs[0] = '{raw: 16'h9966, ins_eq: 1'b0, ena_gap: 1'b0, exp: 8'hA5};
        vecs[1] = '{raw: 16'h9966, ins_eq: 1'b1, ena_gap: 1'b1, exp: 8'hA5};
        vecs[2] = '{raw: 16'h5AA5, ins_eq: 1'b1, ena_gap: 1'b0, exp: 8'h3C};
        vecs[3] = '{raw: 16'hAAAA, ins_eq: 1'b0, ena_gap: 1'b1, exp: 8'hFF};
        vecs[4] = '{raw: 16'h5555, ins_eq: 1'b0, ena_gap: 1'b0, exp: 8'h00};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ena = 1'b1;
        chk("reset_data", data_out, 8'h00);
        chk("reset_valid", {7'd0, data_valid}, 8'h00);
        chk("reset_overrun", {7'd0, overrun}, 8'h00);
        chk("reset_health", {7'd0, health_fail}, 8'h00);

        for (int v = 0; v < 5; v++) begin
            for (int p = 0; p < 8; p++) begin
                logic e;
                e = p[0];
                send_bit(vecs[v].raw[15 - 2 * p]);
                if (p == 7) chk($sformatf("v%0d_valid_before_last", v), {7'd0, data_valid}, 8'h00);
                send_bit(vecs[v].raw[14 - 2 * p]);
                if (vecs[v].ins_eq && p < 7) begin
                    send_bit(e);
                    send_bit(e);
                end
                if (vecs[v].ena_gap && p < 7) begin
                    ena = 1'b0;
                    raw_valid = 1'b1;
                    for (int g = 0; g < 3; g++) begin
                        raw_bit = g[0];
                        @(posedge clk);
                        #1;
                    end
                    raw_valid = 1'b0;
                    ena = 1'b1;
                end
            end
            chk($sformatf("v%0d_data", v), data_out, vecs[v].exp);
            chk($sformatf("v%0d_valid", v), {7'd0, data_valid}, 8'h01);
            chk($sformatf("v%0d_overrun", v), {7'd0, overrun}, 8'h00);
            pulse_ack();
            chk($sformatf("v%0d_valid_after_ack", v), {7'd0, data_valid}, 8'h00);
        end

        // Enable dropped between the two bits of a pair.
        send_bit(1'b1);
        ena = 1'b0;
        @(posedge clk);
        #1;
        ena = 1'b1;
        send_bits(16'h9966, 16);
        chk("midpair_data", data_out, 8'hA5);
        chk("midpair_valid", {7'd0, data_valid}, 8'h01);
        pulse_ack();

        // Second byte arrives while the first is unconsumed.
        send_bits(16'h9966, 16);
        send_bits(16'h5AA5, 16);
        chk("ovr_data", data_out, 8'hA5);
        chk("ovr_valid", {7'd0, data_valid}, 8'h01);
        chk("ovr_flag", {7'd0, overrun}, 8'h01);
        pulse_ack();
        chk("ovr_valid_after_ack", {7'd0, data_valid}, 8'h00);
        chk("ovr_flag_sticky", {7'd0, overrun}, 8'h01);

        // Ack on the exact edge a new byte completes.
        do_reset();
        chk("rst_clears_overrun", {7'd0, overrun}, 8'h00);
        send_bits(16'h9966, 16);
        send_bits(16'h6699, 15);
        ack = 1'b1;
        send_bit(1'b1);
        ack = 1'b0;
        chk("sim_valid", {7'd0, data_valid}, 8'h01);
        chk("sim_data", data_out, 8'h5A);
        chk("sim_overrun", {7'd0, overrun}, 8'h00);
        pulse_ack();
        chk("sim_valid_after_ack", {7'd0, data_valid}, 8'h00);

        // Reset with four debiased bits pending and a byte presented.
        send_bits(16'h9966, 16);
        send_bits(16'h5AA5, 8);
        chk("prerst_valid", {7'd0, data_valid}, 8'h01);
        do_reset();
        chk("midrst_data", data_out, 8'h00);
        chk("midrst_valid", {7'd0, data_valid}, 8'h00);
        chk("midrst_overrun", {7'd0, overrun}, 8'h00);
        send_bits(16'h5AA5, 15);
        chk("fresh_valid_before_last", {7'd0, data_valid}, 8'h00);
        send_bit(1'b1);
        chk("fresh_data", data_out, 8'h3C);
        chk("fresh_valid", {7'd0, data_valid}, 8'h01);
        pulse_ack();

        // Repetition-count health test with 31 consecutive ones.
        do_reset();
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        chk("health_before_limit", {7'd0, health_fail}, 8'h00);
        send_bit(1'b1);
`ifdef TTRNG_HEALTH_EN
        chk("health_at_limit", {7'd0, health_fail}, 8'h01);
`else
        chk("health_at_limit", {7'd0, health_fail}, 8'h00);
`endif
        ena = 1'b0;
        @(posedge clk);
        #1;
        ena = 1'b1;
        send_bits(16'h9966, 16);
`ifdef TTRNG_HEALTH_EN
        chk("health_drop_valid", {7'd0, data_valid}, 8'h00);
        chk("health_drop_overrun", {7'd0, overrun}, 8'h00);
`else
        chk("nohealth_valid", {7'd0, data_valid}, 8'h01);
        chk("nohealth_data", data_out, 8'hA5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttrng_collector.md
# ttrng_collector

Reads the raw entropy bit stream produced by the TTRNG latch network and turns it into debiased 8-bit random bytes. Each consecutive pair of raw bits is run through a von Neumann extractor, surviving bits are packed MSB-first into bytes, and each byte is presented on a single-entry output register with a valid/ack handshake. The block sits between the entropy source and the `uo_out` pins of `tt_um_ttrng`.

## Interface
Parameters:
- `REP_LIMIT`, default 31: repetition-count cutoff for the health test. Legal range 2..255.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `ena` in 1: block enable. When low, raw bits are ignored.
- `raw_bit` in 1: raw entropy bit.
- `raw_valid` in 1: `raw_bit` is sampled on each rising edge where `raw_valid` and `ena` are both high.
- `ack` in 1: consumer has taken `data_out`.
- `data_out` out 8: debiased random byte.
- `data_valid` out 1: `data_out` holds an unconsumed byte.
- `overrun` out 1: sticky flag. Set when a completed byte is dropped.
- `health_fail` out 1: sticky flag. Set when the repetition-count test fails.

## Operation
- Reset value of every output is 0. Internal state after reset: pair FSM = EMPTY, bit count = 0, shift register = 0.
- A reset asserted mid-operation discards the partial byte and any pending output byte.
- Pair FSM, on each accepted raw bit:
  - EMPTY: store the bit as `first`, go to HELD.
  - HELD: if `first != raw_bit`, emit `first` (pair 10 gives 1, pair 01 gives 0). If the two bits are equal, emit nothing. Return to EMPTY.
- `ena` low forces the FSM to EMPTY. The shift register, bit count and handshake state are preserved.
- Packing:
  - An emitted bit shifts into the LSB; the first emitted bit ends up as bit 7.
  - The count increments from 0 to 7.
  - The 8th emitted bit completes a byte: `{shift[6:0], bit}`.
- Byte hand-off, on the edge the byte completes:
  - If the output register is free (`data_valid` = 0, or `ack` = 1 on this same edge): load `data_out`, set `data_valid` = 1, clear the count.
  - Otherwise: drop the byte, set `overrun`, clear the count.
- Handshake: a transfer occurs on any edge where `data_valid` = 1 and `ack` = 1. After that edge `data_valid` = 0, unless a new byte loads on the same edge, in which case it stays 1 with the new byte. `ack` while `data_valid` = 0 has no effect.
- `data_out` is stable while `data_valid` = 1.

## Timing
- Latency: the byte appears with `data_valid` = 1 immediately after the edge that accepts the second raw bit of the 8th surviving pair. There are no extra pipeline cycles.
- Throughput: at most one byte per 16 accepted raw bits.
- `ack` is sampled combinationally on the edge. The consumer must hold `ack` until it sees `data_valid` fall, or deassert it after one cycle.
- Sticky flags clear only on reset.

## Configuration
Macro: `TTRNG_HEALTH_EN`.

Defined:
- A repetition counter (8-bit, saturating) tracks consecutive identical accepted raw bits. It starts at 1 on the first accepted bit and on each change of value.
- When the counter reaches `REP_LIMIT`, `health_fail` is set on that edge.
- While `health_fail` = 1:
  - Completed bytes are discarded without setting `overrun`.
  - A byte already presented still completes its handshake normally.
- Reset clears the counter and the last-bit register.

Not defined:
- `health_fail` is tied to 0 and no counter logic is built.
- `REP_LIMIT` is ignored.

## Test plan
- Reset with `ena`=1, feed raw pairs 10,01,10,01,01,10,01,10 (`raw_valid`=1 every cycle) -> `data_out`=0xA5 and `data_valid`=1 after the 16th accepted bit. `overrun`=0 and `health_fail`=0.
- Same stream with pairs 00 and 11 interleaved, and `ena` low for 3 cycles between full pairs -> still 0xA5, since equal pairs are discarded and `ena` low only resets the pair FSM.
- `ena` dropped between the two bits of a pair -> that pair is discarded and the next two accepted bits form a new pair.
- Produce 0xA5 with `ack` held 0, then a second byte 0x3C -> `data_out` stays 0xA5 and `overrun`=1. Then pulse `ack` -> `data_valid`=0.
- Present 0xA5, then assert `ack` on the exact edge that completes 0x5A -> `data_valid` stays 1, `data_out`=0x5A, `overrun`=0.
- Pulse `rst_n`=0 for 1 cycle with 4 debiased bits pending and `data_valid`=1 -> all outputs 0. The next byte needs 8 fresh surviving pairs.
- With `TTRNG_HEALTH_EN` and `REP_LIMIT`=31: 31 consecutive raw 1s -> `health_fail`=1 on the 31st accepted bit. Any later completed bytes are dropped and `overrun` stays 0.
- Without the macro, the same 31 consecutive raw 1s leave `health_fail`=0.
